z80_irq_ctrl: RTL and testbench
===============================

Z80_IRQ_CTRL -- requirements
Module: z80_irq_ctrl

Interface
REQ-001 The block SHALL have parameter IO_BASE, default 8'h10, which is the I/O port base; the block occupies ports IO_BASE..IO_BASE+3.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock, the same clock that drives the CPU-clock divider.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port irq_src, input, 4 bits: interrupt sources, rising-edge sensitive; bit 0 has the highest priority.
REQ-005 The block SHALL have ports cpu_m1_n, cpu_iorq_n, cpu_rd_n and cpu_wr_n, each input, 1 bit: Z80 bus strobes, active-low.
REQ-006 The block SHALL have port cpu_addr, input, 8 bits: low byte of the Z80 address bus.
REQ-007 The block SHALL have port cpu_d_in, input, 8 bits: CPU write data.
REQ-008 The block SHALL have port d_out, output, 8 bits: read data or interrupt vector.
REQ-009 The block SHALL have port d_oe, output, 1 bit: high while d_out is to be driven onto the CPU data bus.
REQ-010 The block SHALL have port int_n, output, 1 bit: Z80 nINT, active-low.

Function
REQ-011 The block SHALL define its bus conditions as follows:
- ack = ~cpu_m1_n & ~cpu_iorq_n;
- io_rd = cpu_m1_n & ~cpu_iorq_n & ~cpu_rd_n & (cpu_addr[7:2] == IO_BASE[7:2]);
- io_wr is the same as io_rd with ~cpu_wr_n in place of ~cpu_rd_n.
REQ-012 A pending[i] bit SHALL set on the clk at which source i shows a rising edge, i.e. it is sampled high after being sampled low.
REQ-013 int_n SHALL be combinationally equal to ~|(pending & mask).
REQ-014 Each register write SHALL take effect once, on the first clk at which io_wr is high; further cycles of the same strobe SHALL have no effect.
REQ-015 The register map SHALL be:
- +0: read returns {4'h0, pending}; write loads mask <= cpu_d_in[3:0].
- +1: read returns {4'h0, mask}; write clears pending bits where cpu_d_in[i] = 1.
- +2: read returns {vec_base, 4'h0}; write loads vec_base <= cpu_d_in[7:4].
- +3: read returns 8'h00; write is ignored.
REQ-016 While io_rd is high, d_oe SHALL be 1 and d_out SHALL carry the addressed register, combinationally.
REQ-017 The acknowledge FSM SHALL have two states, IDLE and ACK.
REQ-018 In IDLE, when ack is high, the FSM SHALL move to ACK and latch idx, the lowest i with pending[i] & mask[i]; if there is none, it SHALL latch idx = 3'd7 (spurious).
REQ-019 In ACK, d_oe SHALL be 1 and d_out SHALL equal {vec_base, idx, 1'b0}; idx SHALL stay frozen for the whole cycle.
REQ-020 In ACK, when ack goes low, the FSM SHALL return to IDLE and clear pending[idx] on that clk, unless idx = 7.
REQ-021 d_oe SHALL be 0 and d_out SHALL be 8'h00 whenever neither io_rd nor ACK is active.
REQ-022 When a pending bit sets and clears on the same clk (by ack or by a +1 write), set SHALL win.
REQ-023 A source edge arriving during ACK SHALL only set its pending bit and SHALL NOT change idx.
REQ-024 Masked sources SHALL still set pending; unmasking a source SHALL assert int_n on the same clk as the mask write.

Reset
REQ-025 On reset, pending, mask and vec_base SHALL be 0, and the state SHALL be IDLE.
REQ-026 On reset, int_n SHALL be 1, d_oe SHALL be 0 and d_out SHALL be 8'h00.
REQ-027 The edge-detect history and synchronizer flops SHALL keep tracking irq_src during reset, so a source held high across reset release is not an edge.
REQ-028 A reset asserted during ACK SHALL abort the acknowledge with no pending clear; d_oe SHALL be 0 on the next clk.

Configuration
REQ-029 With the macro Z80_IRQ_SYNC_EN defined, each irq_src bit SHALL pass through a two-flop synchronizer before edge detection, adding 2 clk of latency from source to pending.
REQ-030 Without Z80_IRQ_SYNC_EN, irq_src SHALL be sampled directly, so pending sets on the first clk at which the source is sampled high after low.

Structure
REQ-031 A shared package z80_irq_pkg SHALL hold:
- the FSM state enum (IDLE, ACK);
- the register offsets REG_PEND = 2'd0, REG_CLR = 2'd1, REG_VEC = 2'd2;
- NSRC = 4;
- SPURIOUS_IDX = 3'd7.
REQ-032 A single sub-module irq_edge_det SHALL contain the per-source optional synchronizer and rising-edge detector, and SHALL be instantiated 4 times.

Verification
REQ-033 The bench SHALL check masking and vectoring: with mask = 4'hF and vec_base = 4'hA, pulse irq_src[2] -> int_n low; during ack, d_out = 8'hA4 with d_oe = 1; after ack release, pending = 0 and int_n = 1.
REQ-034 The bench SHALL check priority: pulse irq_src[3] and irq_src[1] together -> first ack vector idx = 1; int_n stays low; second ack vector idx = 3; then int_n = 1.
REQ-035 The bench SHALL check masked sources: with mask = 4'h0, pulse irq_src[0] -> int_n = 1 and a read of +0 returns 8'h01; a write of mask = 4'h1 -> int_n low on the same clk.
REQ-036 The bench SHALL check spurious ack and write-clear: ack with nothing pending and vec_base = 4'h3 -> d_out = 8'h3E; writing 8'h0F to +1 clears all pending bits.
REQ-037 The bench SHALL check write-strobe qualification: a 3-clk io_wr to +0 applies the mask once; an irq_src[0] edge on the same clk as a +1 clear of bit 0 leaves pending[0] = 1.
REQ-038 The bench SHALL check reset and latency: reset asserted mid-ACK -> d_oe = 0 and int_n = 1 on the next clk, with all registers 0; with Z80_IRQ_SYNC_EN, edge-to-pending latency measures exactly 2 clk more than without it.

Source files
------------

// File: rtl/z80_irq_pkg.sv
// Shared types and constants for the Z80 interrupt controller.
// Holds the acknowledge FSM states, register offsets and the priority picker.
package z80_irq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } ack_state_t;

    localparam logic [1:0] REG_PEND     = 2'd0;
    localparam logic [1:0] REG_CLR      = 2'd1;
    localparam logic [1:0] REG_VEC      = 2'd2;
    localparam int         NSRC         = 4;
    localparam logic [2:0] SPURIOUS_IDX = 3'd7;

    // Lowest set bit wins; no request at all yields the spurious index.
    function automatic logic [2:0] first_active(input logic [NSRC-1:0] req);
        first_active = SPURIOUS_IDX;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) first_active = 3'(i);
        end
    endfunction

endpackage

// File: rtl/irq_edge_det.sv
// Per-source rising-edge detector; define Z80_IRQ_SYNC_EN for a 2-flop input synchronizer.
// Latency: rise is combinational from the sampled level (+2 clk with the synchronizer); no backpressure.
module irq_edge_det (
    input  logic clk,
    input  logic src,
    output logic rise
);

    logic sampled;
    logic hist;

`ifdef Z80_IRQ_SYNC_EN
    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        sync1 <= src;
        sync2 <= sync1;
    end

    assign sampled = sync2;
`else
    assign sampled = src;
`endif

    // Deliberately unreset so a source held high across reset release is not seen as an edge.
    always_ff @(posedge clk) begin
        hist <= sampled;
    end

    assign rise = sampled & ~hist;

endmodule

// File: rtl/z80_irq_ctrl.sv
// Z80 mode-0/2 style interrupt controller: 4 edge sources, mask, vector base, ack FSM (Z80_IRQ_SYNC_EN adds input sync).
// Latency: reads and the ack vector are combinational, register writes apply on the first io_wr clk; no backpressure.
module z80_irq_ctrl
    import z80_irq_pkg::*;
#(
    parameter logic [7:0] IO_BASE = 8'h10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq_src,
    input  logic       cpu_m1_n,
    input  logic       cpu_iorq_n,
    input  logic       cpu_rd_n,
    input  logic       cpu_wr_n,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       int_n
);

    logic            ack;
    logic            addr_hit;
    logic            io_rd;
    logic            io_wr;
    logic            wr_prev;
    logic            wr_first;
    logic [1:0]      reg_off;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] clr_wr;
    logic [NSRC-1:0] clr_ack;
    logic [3:0]      vec_base;
    ack_state_t      state;
    ack_state_t      state_nxt;
    logic [2:0]      idx;
    logic [2:0]      idx_nxt;
    logic            ack_done;

    assign ack      = ~cpu_m1_n & ~cpu_iorq_n;
    assign addr_hit = (cpu_addr[7:2] == IO_BASE[7:2]);
    assign io_rd    = cpu_m1_n & ~cpu_iorq_n & ~cpu_rd_n & addr_hit;
    assign io_wr    = cpu_m1_n & ~cpu_iorq_n & ~cpu_wr_n & addr_hit;
    assign reg_off  = cpu_addr[1:0];
    assign wr_first = io_wr & ~wr_prev;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        irq_edge_det u_edge (
            .clk  (clk),
            .src  (irq_src[g]),
            .rise (rise[g])
        );
    end

    assign clr_wr  = (wr_first && reg_off == REG_CLR) ? cpu_d_in[NSRC-1:0] : '0;
    assign clr_ack = (ack_done && idx != SPURIOUS_IDX) ? (NSRC'(1) << idx) : '0;
    assign int_n   = ~|(pending & mask);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ack_done  = 1'b0;
        d_oe      = 1'b0;
        d_out     = 8'h00;
        case (state)
            IDLE: begin
                if (ack) begin
                    state_nxt = ACK;
                    idx_nxt   = first_active(pending & mask);
                end
            end
            ACK: begin
                d_oe  = 1'b1;
                d_out = {vec_base, idx, 1'b0};
                if (!ack) begin
                    state_nxt = IDLE;
                    ack_done  = 1'b1;
                end
            end
        endcase
        if (io_rd) begin
            d_oe = 1'b1;
            case (reg_off)
                REG_PEND: d_out = {4'h0, pending};
                REG_CLR:  d_out = {4'h0, mask};
                REG_VEC:  d_out = {vec_base, 4'h0};
                default:  d_out = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            pending  <= '0;
            mask     <= '0;
            vec_base <= '0;
            wr_prev  <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            wr_prev <= io_wr;
            // New edges override any clear landing on the same clk.
            pending <= (pending & ~(clr_wr | clr_ack)) | rise;
            if (wr_first) begin
                case (reg_off)
                    REG_PEND: mask     <= cpu_d_in[NSRC-1:0];
                    REG_VEC:  vec_base <= cpu_d_in[7:4];
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_z80_irq_ctrl.sv
// Directed and randomized bench for z80_irq_ctrl against a cycle-level behavioural model.
module tb_z80_irq_ctrl;

    localparam logic [7:0] IOB = 8'h10;
`ifdef Z80_IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] irq_src = 4'h0;
    logic       m1_n   = 1'b1;
    logic       iorq_n = 1'b1;
    logic       rd_n   = 1'b1;
    logic       wr_n   = 1'b1;
    logic [7:0] addr   = 8'h00;
    logic [7:0] din    = 8'h00;
    wire  [7:0] d_out;
    wire        d_oe;
    wire        int_n;

    always #5 clk = ~clk;

    z80_irq_ctrl #(.IO_BASE(IOB)) dut (
        .clk        (clk),
        .reset      (rst),
        .irq_src    (irq_src),
        .cpu_m1_n   (m1_n),
        .cpu_iorq_n (iorq_n),
        .cpu_rd_n   (rd_n),
        .cpu_wr_n   (wr_n),
        .cpu_addr   (addr),
        .cpu_d_in   (din),
        .d_out      (d_out),
        .d_oe       (d_oe),
        .int_n      (int_n)
    );

    int nchecks = 0;
    int nerr    = 0;

    // Behavioural model state
    logic [3:0] m_pend    = 4'h0;
    logic [3:0] m_mask    = 4'h0;
    logic [3:0] m_vec     = 4'h0;
    bit         m_in_ack  = 1'b0;
    logic [2:0] m_idx     = 3'd0;
    bit         m_wr_prev = 1'b0;
    logic [3:0] smp [3]   = '{4'h0, 4'h0, 4'h0};

    function automatic bit b_ack();
        return !m1_n && !iorq_n;
    endfunction
    function automatic bit b_rd();
        return m1_n && !iorq_n && !rd_n && (addr[7:2] == IOB[7:2]);
    endfunction
    function automatic bit b_wr();
        return m1_n && !iorq_n && !wr_n && (addr[7:2] == IOB[7:2]);
    endfunction

    function automatic logic [7:0] exp_dout();
        if (b_rd()) begin
            case (addr[1:0])
                2'd0:    return {4'h0, m_pend};
                2'd1:    return {4'h0, m_mask};
                2'd2:    return {m_vec, 4'h0};
                default: return 8'h00;
            endcase
        end
        if (m_in_ack) return {m_vec, m_idx, 1'b0};
        return 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("model int_n", {7'b0, int_n}, {7'b0, (m_pend & m_mask) == 4'h0});
        chk("model d_oe", {7'b0, d_oe}, {7'b0, b_rd() || m_in_ack});
        chk("model d_out", d_out, exp_dout());
    endtask

    // Advance one clk: derive the model's next state from the current inputs, then compare.
    task automatic cyc();
        logic [3:0] rise, clr, n_pend, n_mask, n_vec;
        logic [2:0] n_idx;
        bit         n_in_ack, wr_first;
        rise = (SYNC_LAT != 0) ? (smp[1] & ~smp[2]) : (irq_src & ~smp[0]);
        wr_first = b_wr() && !m_wr_prev;
        clr = 4'h0;
        if (wr_first && addr[1:0] == 2'd1) clr = din[3:0];
        if (m_in_ack && !b_ack() && m_idx != 3'd7) clr[m_idx[1:0]] = 1'b1;
        n_pend = (m_pend & ~clr) | rise;
        n_mask = (wr_first && addr[1:0] == 2'd0) ? din[3:0] : m_mask;
        n_vec  = (wr_first && addr[1:0] == 2'd2) ? din[7:4] : m_vec;
        n_in_ack = m_in_ack;
        n_idx    = m_idx;
        if (!m_in_ack && b_ack()) begin
            n_in_ack = 1'b1;
            n_idx    = 3'd7;
            for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) n_idx = 3'(i);
        end else if (m_in_ack && !b_ack()) begin
            n_in_ack = 1'b0;
        end
        @(posedge clk);
        #1;
        smp[2] = smp[1];
        smp[1] = smp[0];
        smp[0] = irq_src;
        if (rst) begin
            m_pend = 4'h0; m_mask = 4'h0; m_vec = 4'h0; m_in_ack = 1'b0; m_wr_prev = 1'b0;
        end else begin
            m_pend = n_pend; m_mask = n_mask; m_vec = n_vec;
            m_in_ack = n_in_ack; m_idx = n_idx; m_wr_prev = b_wr();
        end
        chk_outputs();
    endtask

    task automatic bus_idle();
        m1_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic io_wr(input logic [1:0] off, input logic [7:0] data, input int n);
        addr = IOB + 8'(off); din = data; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (n) cyc();
        bus_idle();
        cyc();
    endtask

    task automatic rd_check(input string tag, input logic [1:0] off, input logic [7:0] exp);
        addr = IOB + 8'(off); iorq_n = 1'b0; rd_n = 1'b0;
        #1;
        chk(tag, d_out, exp);
        chk({tag, " oe"}, {7'b0, d_oe}, 8'h01);
        chk_outputs();
        bus_idle();
        #1;
    endtask

    task automatic pulse(input logic [3:0] bits);
        irq_src = irq_src | bits;
        cyc();
        irq_src = irq_src & ~bits;
        cyc();
        repeat (SYNC_LAT) cyc();
    endtask

    task automatic ack_begin();
        m1_n = 1'b0; iorq_n = 1'b0;
        cyc();
    endtask

    task automatic ack_end();
        bus_idle();
        cyc();
    endtask

    initial begin
        int lat;
        bus_idle();
        repeat (4) cyc();
        chk("reset int_n", {7'b0, int_n}, 8'h01);
        chk("reset d_oe", {7'b0, d_oe}, 8'h00);
        chk("reset d_out", d_out, 8'h00);
        rst = 1'b0;
        cyc();
        rd_check("reset pend", 2'd0, 8'h00);
        rd_check("reset mask", 2'd1, 8'h00);
        rd_check("reset vec", 2'd2, 8'h00);

        // Masking and vectoring
        io_wr(2'd0, 8'h0F, 1);
        io_wr(2'd2, 8'hA0, 1);
        pulse(4'b0100);
        chk("vec int_n low", {7'b0, int_n}, 8'h00);
        ack_begin();
        chk("vec d_out", d_out, 8'hA4);
        chk("vec d_oe", {7'b0, d_oe}, 8'h01);
        cyc();
        ack_end();
        chk("vec int_n released", {7'b0, int_n}, 8'h01);
        rd_check("vec pend cleared", 2'd0, 8'h00);

        // Priority
        pulse(4'b1010);
        ack_begin();
        chk("prio first", d_out, 8'hA2);
        ack_end();
        chk("prio int_n held", {7'b0, int_n}, 8'h00);
        ack_begin();
        chk("prio second", d_out, 8'hA6);
        ack_end();
        chk("prio int_n done", {7'b0, int_n}, 8'h01);

        // Masked sources still latch; unmask asserts immediately
        io_wr(2'd0, 8'h00, 1);
        pulse(4'b0001);
        chk("masked int_n", {7'b0, int_n}, 8'h01);
        rd_check("masked pend", 2'd0, 8'h01);
        addr = IOB; din = 8'h01; iorq_n = 1'b0; wr_n = 1'b0;
        cyc();
        chk("unmask int_n", {7'b0, int_n}, 8'h00);
        bus_idle();
        cyc();

        // Write-clear and spurious ack
        io_wr(2'd0, 8'h00, 1);
        pulse(4'hF);
        rd_check("all pend", 2'd0, 8'h0F);
        io_wr(2'd1, 8'h0F, 1);
        rd_check("clear all", 2'd0, 8'h00);
        io_wr(2'd2, 8'h30, 1);
        ack_begin();
        chk("spurious vec", d_out, 8'h3E);
        chk("spurious oe", {7'b0, d_oe}, 8'h01);
        ack_end();

        // Multi-clk write applies once; set beats a coincident clear
        addr = IOB; iorq_n = 1'b0; wr_n = 1'b0; din = 8'h05;
        cyc();
        din = 8'h0A;
        cyc();
        cyc();
        bus_idle();
        cyc();
        rd_check("write once", 2'd1, 8'h05);
        pulse(4'b0001);
        irq_src[0] = 1'b1;
        repeat (SYNC_LAT) cyc();
        io_wr(2'd1, 8'h01, 1);
        irq_src[0] = 1'b0;
        cyc();
        rd_check("set wins", 2'd0, 8'h01);

        // Reset mid-ACK; a level held across reset is not an edge
        ack_begin();
        chk("pre-reset ack", d_out, 8'h30);
        irq_src[1] = 1'b1;
        rst = 1'b1;
        cyc();
        chk("abort d_oe", {7'b0, d_oe}, 8'h00);
        chk("abort int_n", {7'b0, int_n}, 8'h01);
        bus_idle();
        rd_check("abort pend", 2'd0, 8'h00);
        rd_check("abort mask", 2'd1, 8'h00);
        rd_check("abort vec", 2'd2, 8'h00);
        repeat (3) cyc();
        rst = 1'b0;
        repeat (4) cyc();
        rd_check("held level", 2'd0, 8'h00);
        irq_src = 4'h0;

        // Edge-to-pending latency
        io_wr(2'd0, 8'h0F, 1);
        repeat (3) cyc();
        irq_src[3] = 1'b1;
        lat = 0;
        do begin
            cyc();
            lat++;
        end while (int_n && lat < 10);
        chk("latency", 8'(lat), 8'(1 + SYNC_LAT));
        irq_src = 4'h0;
        io_wr(2'd1, 8'h0F, 1);

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            int op;
            logic [1:0] off;
            irq_src = 4'($urandom);
            op  = $urandom_range(0, 3);
            off = 2'($urandom_range(0, 3));
            addr = ($urandom_range(0, 7) == 0) ? (8'h24 + 8'(off)) : (IOB + 8'(off));
            case (op)
                0: cyc();
                1: begin
                    din = 8'($urandom);
                    iorq_n = 1'b0; wr_n = 1'b0;
                    repeat ($urandom_range(1, 3)) cyc();
                    bus_idle();
                    cyc();
                end
                2: begin
                    iorq_n = 1'b0; rd_n = 1'b0;
                    #1;
                    chk_outputs();
                    cyc();
                    bus_idle();
                end
                default: begin
                    m1_n = 1'b0; iorq_n = 1'b0;
                    repeat ($urandom_range(1, 3)) cyc();
                    bus_idle();
                    cyc();
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
